conv_norm_div: RTL and testbench



---
 rtl/conv_norm_div_if.sv | 29 ++
 rtl/conv_norm_div.sv | 134 +++++++++++++
 tb/tb_conv_norm_div.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_norm_div_if.sv
// rtl/conv_norm_div_if.sv - input/result handshake bundle for the normalisation divider
interface conv_norm_div_if #(
  parameter int NW = 16,
  parameter int DW = 8,
  parameter int OW = 8,
  parameter int TW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] num;
  logic [DW-1:0] den;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_pix;
  logic [TW-1:0] out_tag;
  logic          sat;
  logic          div_zero;

  modport master (
    output in_valid, num, den, in_tag, out_ready,
    input  in_ready, out_valid, out_pix, out_tag, sat, div_zero
  );

  modport slave (
    input  in_valid, num, den, in_tag, out_ready,
    output in_ready, out_valid, out_pix, out_tag, sat, div_zero
  );
endinterface

// File: rtl/conv_norm_div.sv
// rtl/conv_norm_div.sv - rounded, saturating restoring divider producing one filtered pixel
module conv_norm_div #(
  parameter int NW = 16,
  parameter int DW = 8,
  parameter int OW = 8,
  parameter int TW = 2
) (
  input logic            clk,
  input logic            rst_n,
  conv_norm_div_if.slave bus
);
  localparam int CW = $clog2(NW + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [NW:0]   dividend_q, dividend_d;
  logic [DW-1:0] den_q, den_d;
  logic [DW:0]   rem_q, rem_d;
  logic [NW:0]   quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [OW-1:0] pix_q, pix_d;
  logic [TW-1:0] out_tag_q, out_tag_d;
  logic          sat_q, sat_d;
  logic          dz_q, dz_d;

  logic [DW:0]   rem_shift;
  logic [DW:0]   rem_sub;
  logic          take;
  logic [NW:0]   quo_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      pix_q      <= '0;
      out_tag_q  <= '0;
      sat_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      pix_q      <= pix_d;
      out_tag_q  <= out_tag_d;
      sat_q      <= sat_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    den_d      = den_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    pix_d      = pix_q;
    out_tag_d  = out_tag_q;
    sat_d      = sat_q;
    dz_d       = dz_q;

    // Remainder stays below den, so its top bit is always free for the incoming dividend bit.
    rem_shift = {rem_q[DW-1:0], dividend_q[NW]};
    rem_sub   = rem_shift - {1'b0, den_q};
    take      = (rem_shift >= {1'b0, den_q});
    quo_next  = {quo_q[NW-1:0], take};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Adding den/2 before dividing turns truncation into round-half-up.
          dividend_d = {1'b0, bus.num} + {{(NW + 1 - DW){1'b0}}, bus.den >> 1};
          den_d      = bus.den;
          tag_d      = bus.in_tag;
          rem_d      = '0;
          quo_d      = '0;
          if (bus.den != '0) begin
            cnt_d   = CW'(NW + 1);
            state_d = CALC;
          end else begin
            pix_d     = '0;
            sat_d     = 1'b0;
            dz_d      = 1'b1;
            out_tag_d = bus.in_tag;
            state_d   = DONE;
          end
        end
      end
      CALC: begin
        rem_d      = take ? rem_sub : rem_shift;
        dividend_d = {dividend_q[NW-1:0], 1'b0};
        quo_d      = quo_next;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          out_tag_d = tag_q;
          dz_d      = 1'b0;
          if (|quo_next[NW:OW]) begin
            pix_d = '1;
            sat_d = 1'b1;
          end else begin
            pix_d = quo_next[OW-1:0];
            sat_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_pix   = pix_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.sat       = sat_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_conv_norm_div.sv
// tb/tb_conv_norm_div.sv - directed scoreboard bench for conv_norm_div
module tb_conv_norm_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_norm_div_if bus ();

  conv_norm_div dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] tag;
    logic       sat;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [15:0] n, input logic [7:0] d, input logic [1:0] t);
    exp_t e;
    int q;
    e.tag = t;
    if (d == 8'd0) begin
      e.pix = 8'd0;
      e.sat = 1'b0;
      e.dz  = 1'b1;
    end else begin
      q = (int'(n) + int'(d) / 2) / int'(d);
      e.dz = 1'b0;
      if (q > 255) begin
        e.pix = 8'hff;
        e.sat = 1'b1;
      end else begin
        e.pix = q[7:0];
        e.sat = 1'b0;
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [15:0] n, input logic [7:0] d, input logic [1:0] t, input bit push);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("in_ready_timeout", 32'(w), 32'(0));
    bus.in_valid = 1'b1;
    bus.num      = n;
    bus.den      = d;
    bus.in_tag   = t;
    if (push) sb.push_back(model(n, d, t));
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!bus.out_valid && l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    if (l >= 100) check("out_valid_timeout", 32'(l), 32'(0));
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(0), 32'(1));
      return;
    end
    e = sb.pop_front();
    check("out_pix", 32'(bus.out_pix), 32'(e.pix));
    check("out_tag", 32'(bus.out_tag), 32'(e.tag));
    check("sat", 32'(bus.sat), 32'(e.sat));
    check("div_zero", 32'(bus.div_zero), 32'(e.dz));
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", 32'(bus.out_valid), 32'(0));
    check("hs_in_ready", 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    logic [15:0] b_num[3];
    logic [7:0]  b_den[3];
    logic [1:0]  b_tag[3];

    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_pix", 32'(bus.out_pix), 32'(0));
    check("rst_out_tag", 32'(bus.out_tag), 32'(0));
    check("rst_sat", 32'(bus.sat), 32'(0));
    check("rst_div_zero", 32'(bus.div_zero), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Rounding down, then backpressure with a competing input that must be ignored
    send(16'd1000, 8'd8, 2'b01, 1'b1);
    wait_valid(lat);
    check("lat_round", 32'(lat), 32'(17));
    check_out();
    bus.in_valid = 1'b1;
    bus.num      = 16'd50;
    bus.den      = 8'd5;
    bus.in_tag   = 2'b10;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'(1));
      check("bp_out_pix", 32'(bus.out_pix), 32'(125));
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    bus.in_valid = 1'b0;
    handshake();

    send(16'd1004, 8'd8, 2'b10, 1'b1);
    wait_valid(lat);
    check_out();
    handshake();

    send(16'd65535, 8'd1, 2'b11, 1'b1);
    wait_valid(lat);
    check_out();
    handshake();

    send(16'd2040, 8'd8, 2'b00, 1'b1);
    wait_valid(lat);
    check_out();
    handshake();

    send(16'd500, 8'd0, 2'b01, 1'b1);
    wait_valid(lat);
    check("lat_dz", 32'(lat), 32'(0));
    check_out();
    handshake();

    // Back-to-back with out_ready held high
    b_num[0] = 16'd300; b_den[0] = 8'd3;   b_tag[0] = 2'b01;
    b_num[1] = 16'd255; b_den[1] = 8'd255; b_tag[1] = 2'b10;
    b_num[2] = 16'd7;   b_den[2] = 8'd2;   b_tag[2] = 2'b11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(b_num[i], b_den[i], b_tag[i], 1'b1);
      if (i > 0) check("b2b_gap", 32'(acc_cyc - prev_acc), 32'(19));
      prev_acc = acc_cyc;
      wait_valid(lat);
      check_out();
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during the fifth CALC cycle aborts the operation
    send(16'd999, 8'd7, 2'b11, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("mid_rst_out_pix", 32'(bus.out_pix), 32'(0));
    check("mid_rst_out_tag", 32'(bus.out_tag), 32'(0));
    check("mid_rst_sat", 32'(bus.sat), 32'(0));
    check("mid_rst_div_zero", 32'(bus.div_zero), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    send(16'd100, 8'd4, 2'b10, 1'b1);
    wait_valid(lat);
    check("lat_after_rst", 32'(lat), 32'(17));
    check_out();
    handshake();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
